avl_mm_image_slave: RTL and testbench

- Avalon-MM slave that terminates the 17-bit address / 8-bit data master exported by the JTAG debug system.
- Gives the host byte access to an on-chip pixel buffer (address bit 16 = 0) and a small control/status register file (address bit 16 = 1).
- Drives start and image geometry to the CV engine. Gives the engine a dedicated read port into the pixel buffer.

---
 rtl/avl_mm_image_slave.sv | 235 +++++++++++++++++++++++
 tb/tb_avl_mm_image_slave.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/avl_mm_image_slave.sv
// ---------------------------------------------------------------------------
// avl_mm_image_slave
//
// Avalon-MM slave behind the JTAG debug master (17-bit byte address, 8-bit
// data). Address bit 16 selects between:
//   0 : on-chip pixel buffer (true dual-port RAM, 2^MEM_AW bytes, aliased)
//   1 : control/status register file, decoded on address bits [3:0]
// The CV engine gets start/geometry outputs and a private read port (B) into
// the pixel buffer.
//
// Build option: define AVS_ACCESS_CNT_EN to add a 16-bit access counter
// readable at ACC_LO (0x6) / ACC_HI (0x7); without it those offsets read 0.
//
// Ports
//   clk_clk, reset_reset        clock, asynchronous active-high reset
//   avs_s0_address/read/write   Avalon request, sampled only in IDLE
//   avs_s0_writedata            write data
//   avs_s0_readdata             registered read data, valid in the ACK cycle
//   avs_s0_waitrequest          (read|write) & ~ack
//   eng_start                   one-cycle start pulse (registered)
//   eng_img_w / eng_img_h       image geometry registers
//   eng_busy / eng_done         engine status inputs
//   eng_rd_addr / eng_rd_data   engine buffer read port, 1-cycle latency
// ---------------------------------------------------------------------------
module avl_mm_image_slave #(
  parameter int unsigned MEM_AW   = 16,
  parameter logic [7:0]  ID_VALUE = 8'hC5
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [16:0]       avs_s0_address,
  input  logic              avs_s0_read,
  output logic [7:0]        avs_s0_readdata,
  input  logic              avs_s0_write,
  input  logic [7:0]        avs_s0_writedata,
  output logic              avs_s0_waitrequest,
  output logic              eng_start,
  output logic [7:0]        eng_img_w,
  output logic [7:0]        eng_img_h,
  input  logic              eng_busy,
  input  logic              eng_done,
  input  logic [MEM_AW-1:0] eng_rd_addr,
  output logic [7:0]        eng_rd_data
);

  localparam int unsigned DEPTH = 32'd1 << MEM_AW;

  localparam logic [3:0] OFF_CTRL    = 4'h0;
  localparam logic [3:0] OFF_STATUS  = 4'h1;
  localparam logic [3:0] OFF_IMG_W   = 4'h2;
  localparam logic [3:0] OFF_IMG_H   = 4'h3;
  localparam logic [3:0] OFF_ID      = 4'h4;
  localparam logic [3:0] OFF_SCRATCH = 4'h5;
`ifdef AVS_ACCESS_CNT_EN
  localparam logic [3:0] OFF_ACC_LO  = 4'h6;
  localparam logic [3:0] OFF_ACC_HI  = 4'h7;
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_ACK     = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic              ack_s;
  logic              is_reg_s;
  logic [3:0]        off_s;
  logic [MEM_AW-1:0] buf_addr_s;
  logic              wr_go_s;
  logic              rd_reg_go_s;
  logic              rd_buf_go_s;
  logic              buf_we_s;
  logic              reg_we_s;
  logic [7:0]        reg_rdata_s;

  logic [7:0] mem_q [0:DEPTH-1];
  logic [7:0] ram_a_q;
  logic [7:0] readdata_q;
  logic [7:0] img_w_q;
  logic [7:0] img_h_q;
  logic [7:0] scratch_q;
  logic       done_q;
  logic       ovr_q;
  logic       start_q;
`ifdef AVS_ACCESS_CNT_EN
  logic [15:0] acc_cnt_q;
`endif

  assign is_reg_s   = avs_s0_address[16];
  assign off_s      = avs_s0_address[3:0];
  assign buf_addr_s = avs_s0_address[MEM_AW-1:0];

  // FSM state register
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; write has priority over read
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (avs_s0_write) begin
          state_d = ST_ACK;
        end else if (avs_s0_read) begin
          state_d = is_reg_s ? ST_ACK : ST_RD_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_WAIT: state_d = ST_ACK;
      ST_ACK:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and request decode; everything is sampled only in IDLE
  always_comb begin
    ack_s              = (state_q == ST_ACK);
    avs_s0_waitrequest = (avs_s0_read | avs_s0_write) & ~ack_s;
    wr_go_s            = (state_q == ST_IDLE) & avs_s0_write;
    rd_reg_go_s        = (state_q == ST_IDLE) & avs_s0_read & ~avs_s0_write & is_reg_s;
    rd_buf_go_s        = (state_q == ST_IDLE) & avs_s0_read & ~avs_s0_write & ~is_reg_s;
    reg_we_s           = wr_go_s & is_reg_s;
    // The write lands on the edge that enters ACK; a reset during the
    // request cycle must suppress it, and the RAM has no reset of its own.
    buf_we_s           = wr_go_s & ~is_reg_s & ~reset_reset;
  end

  // Register read multiplexer
  always_comb begin
    reg_rdata_s = 8'h00;
    case (off_s)
      OFF_STATUS:  reg_rdata_s = {5'b00000, ovr_q, done_q, eng_busy};
      OFF_IMG_W:   reg_rdata_s = img_w_q;
      OFF_IMG_H:   reg_rdata_s = img_h_q;
      OFF_ID:      reg_rdata_s = ID_VALUE;
      OFF_SCRATCH: reg_rdata_s = scratch_q;
`ifdef AVS_ACCESS_CNT_EN
      OFF_ACC_LO:  reg_rdata_s = acc_cnt_q[7:0];
      OFF_ACC_HI:  reg_rdata_s = acc_cnt_q[15:8];
`endif
      default:     reg_rdata_s = 8'h00;
    endcase
  end

  // Pixel buffer port A: Avalon write and read-before-write read
  always_ff @(posedge clk_clk) begin
    if (buf_we_s) begin
      mem_q[buf_addr_s] <= avs_s0_writedata;
    end
    if (rd_buf_go_s) begin
      ram_a_q <= mem_q[buf_addr_s];
    end
  end

  // Pixel buffer port B: engine read, returns old data on a same-address write
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      eng_rd_data <= 8'h00;
    end else begin
      eng_rd_data <= mem_q[eng_rd_addr];
    end
  end

  // Avalon read data: registers load from IDLE, buffer loads from RD_WAIT
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      readdata_q <= 8'h00;
    end else if (rd_reg_go_s) begin
      readdata_q <= reg_rdata_s;
    end else if (state_q == ST_RD_WAIT) begin
      readdata_q <= ram_a_q;
    end
  end

  // Writable configuration registers
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      img_w_q   <= 8'h00;
      img_h_q   <= 8'h00;
      scratch_q <= 8'h00;
    end else if (reg_we_s) begin
      if (off_s == OFF_IMG_W)   img_w_q   <= avs_s0_writedata;
      if (off_s == OFF_IMG_H)   img_h_q   <= avs_s0_writedata;
      if (off_s == OFF_SCRATCH) scratch_q <= avs_s0_writedata;
    end
  end

  // Start pulse and sticky DONE/OVR flags; a set beats a same-cycle clear
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      start_q <= reg_we_s & (off_s == OFF_CTRL) & avs_s0_writedata[0] & ~eng_busy;
      if (eng_done) begin
        done_q <= 1'b1;
      end else if (reg_we_s && (off_s == OFF_STATUS) && avs_s0_writedata[1]) begin
        done_q <= 1'b0;
      end
      if (reg_we_s && (off_s == OFF_CTRL) && avs_s0_writedata[0] && eng_busy) begin
        ovr_q <= 1'b1;
      end else if (reg_we_s && (off_s == OFF_STATUS) && avs_s0_writedata[2]) begin
        ovr_q <= 1'b0;
      end
    end
  end

`ifdef AVS_ACCESS_CNT_EN
  // Access counter: clear lands on ACK entry, the ACK cycle itself then counts
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      acc_cnt_q <= 16'h0000;
    end else if (reg_we_s && (off_s == OFF_ACC_LO)) begin
      acc_cnt_q <= 16'h0000;
    end else if (ack_s) begin
      acc_cnt_q <= acc_cnt_q + 16'h0001;
    end
  end
`endif

  assign avs_s0_readdata = readdata_q;
  assign eng_start       = start_q;
  assign eng_img_w       = img_w_q;
  assign eng_img_h       = img_h_q;

endmodule

// File: tb/tb_avl_mm_image_slave.sv
// Directed testbench for avl_mm_image_slave (default MEM_AW=16, ID 0xC5).
module tb_avl_mm_image_slave;

  logic        clk_clk;
  logic        reset_reset;
  logic [16:0] avs_s0_address;
  logic        avs_s0_read;
  logic [7:0]  avs_s0_readdata;
  logic        avs_s0_write;
  logic [7:0]  avs_s0_writedata;
  logic        avs_s0_waitrequest;
  logic        eng_start;
  logic [7:0]  eng_img_w;
  logic [7:0]  eng_img_h;
  logic        eng_busy;
  logic        eng_done;
  logic [15:0] eng_rd_addr;
  logic [7:0]  eng_rd_data;

  int total = 0;
  int bad   = 0;
  int start_cnt = 0;

  int         waits;
  logic [7:0] rdat;
  logic [7:0] eng_at_ack;
  int         s0;

  avl_mm_image_slave dut (
    .clk_clk            (clk_clk),
    .reset_reset        (reset_reset),
    .avs_s0_address     (avs_s0_address),
    .avs_s0_read        (avs_s0_read),
    .avs_s0_readdata    (avs_s0_readdata),
    .avs_s0_write       (avs_s0_write),
    .avs_s0_writedata   (avs_s0_writedata),
    .avs_s0_waitrequest (avs_s0_waitrequest),
    .eng_start          (eng_start),
    .eng_img_w          (eng_img_w),
    .eng_img_h          (eng_img_h),
    .eng_busy           (eng_busy),
    .eng_done           (eng_done),
    .eng_rd_addr        (eng_rd_addr),
    .eng_rd_data        (eng_rd_data)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  // Count cycles with eng_start high, sampled mid-cycle.
  always @(negedge clk_clk) begin
    if (eng_start === 1'b1) start_cnt = start_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One Avalon transfer. Counts waitrequest-high cycles (bounded), returns
  // readdata and eng_rd_data seen in the ACK cycle. done_p drives eng_done
  // high during the request cycle only.
  task automatic xfer(input bit wr, input bit rd, input logic [16:0] a,
                      input logic [7:0] d, input bit done_p,
                      output int w, output logic [7:0] r, output logic [7:0] e);
    @(posedge clk_clk); #1;
    avs_s0_write     = wr;
    avs_s0_read      = rd;
    avs_s0_address   = a;
    avs_s0_writedata = d;
    eng_done         = done_p;
    w = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_clk);
      if (avs_s0_waitrequest !== 1'b1) break;
      w = w + 1;
      @(posedge clk_clk); #1;
      eng_done = 1'b0;
    end
    r = avs_s0_readdata;
    e = eng_rd_data;
    @(posedge clk_clk); #1;
    avs_s0_write = 1'b0;
    avs_s0_read  = 1'b0;
    eng_done     = 1'b0;
  endtask

  initial begin
    reset_reset      = 1'b1;
    avs_s0_address   = 17'h00000;
    avs_s0_read      = 1'b1;
    avs_s0_write     = 1'b0;
    avs_s0_writedata = 8'h00;
    eng_busy         = 1'b0;
    eng_done         = 1'b0;
    eng_rd_addr      = 16'h0000;

    // Reset state
    #12;
    check("rst_waitreq_follows_read", {31'd0, avs_s0_waitrequest}, 32'd1);
    avs_s0_read = 1'b0;
    #1;
    check("rst_waitreq_idle", {31'd0, avs_s0_waitrequest}, 32'd0);
    check("rst_readdata", {24'd0, avs_s0_readdata}, 32'h00);
    check("rst_eng_start", {31'd0, eng_start}, 32'd0);
    check("rst_img_w", {24'd0, eng_img_w}, 32'h00);
    check("rst_img_h", {24'd0, eng_img_h}, 32'h00);
    check("rst_eng_rd_data", {24'd0, eng_rd_data}, 32'h00);
    @(posedge clk_clk); #1;
    reset_reset = 1'b0;

    // Buffer write / read latency
    xfer(1'b1, 1'b0, 17'h00010, 8'h5A, 1'b0, waits, rdat, eng_at_ack);
    check("buf_wr_waits", waits, 32'd1);
    xfer(1'b0, 1'b1, 17'h00010, 8'h00, 1'b0, waits, rdat, eng_at_ack);
    check("buf_rd_waits", waits, 32'd2);
    check("buf_rd_data", {24'd0, rdat}, 32'h5A);

    // Register file
    xfer(1'b0, 1'b1, 17'h10004, 8'h00, 1'b0, waits, rdat, eng_at_ack);
    check("id_waits", waits, 32'd1);
    check("id_data", {24'd0, rdat}, 32'hC5);
    xfer(1'b1, 1'b0, 17'h10005, 8'h33, 1'b0, waits, rdat, eng_at_ack);
    xfer(1'b0, 1'b1, 17'h10005, 8'h00, 1'b0, waits, rdat, eng_at_ack);
    check("scratch_rd", {24'd0, rdat}, 32'h33);
    xfer(1'b0, 1'b1, 17'h1000F, 8'h00, 1'b0, waits, rdat, eng_at_ack);
    check("unmapped_rd", {24'd0, rdat}, 32'h00);
    xfer(1'b1, 1'b0, 17'h10002, 8'h12, 1'b0, waits, rdat, eng_at_ack);
    check("img_w_out", {24'd0, eng_img_w}, 32'h12);
    xfer(1'b0, 1'b1, 17'h10002, 8'h00, 1'b0, waits, rdat, eng_at_ack);
    check("img_w_rd", {24'd0, rdat}, 32'h12);
    xfer(1'b1, 1'b0, 17'h10004, 8'h99, 1'b0, waits, rdat, eng_at_ack);
    xfer(1'b0, 1'b1, 17'h10004, 8'h00, 1'b0, waits, rdat, eng_at_ack);
    check("id_readonly", {24'd0, rdat}, 32'hC5);

    // Write and read together: write wins
    xfer(1'b1, 1'b1, 17'h10005, 8'h99, 1'b0, waits, rdat, eng_at_ack);
    check("wr_rd_waits", waits, 32'd1);
    xfer(1'b0, 1'b1, 17'h10005, 8'h00, 1'b0, waits, rdat, eng_at_ack);
    check("wr_rd_write_wins", {24'd0, rdat}, 32'h99);

    // Start pulse, idle engine
    s0 = start_cnt;
    xfer(1'b1, 1'b0, 17'h10000, 8'h01, 1'b0, waits, rdat, eng_at_ack);
    repeat (3) @(posedge clk_clk);
    check("start_pulse_cycles", start_cnt - s0, 32'd1);
    xfer(1'b0, 1'b1, 17'h10001, 8'h00, 1'b0, waits, rdat, eng_at_ack);
    check("status_idle", {24'd0, rdat}, 32'h00);
    xfer(1'b0, 1'b1, 17'h10000, 8'h00, 1'b0, waits, rdat, eng_at_ack);
    check("ctrl_reads_zero", {24'd0, rdat}, 32'h00);

    // Start while busy: no pulse, OVR set
    eng_busy = 1'b1;
    s0 = start_cnt;
    xfer(1'b1, 1'b0, 17'h10000, 8'h01, 1'b0, waits, rdat, eng_at_ack);
    repeat (3) @(posedge clk_clk);
    check("start_blocked", start_cnt - s0, 32'd0);
    xfer(1'b0, 1'b1, 17'h10001, 8'h00, 1'b0, waits, rdat, eng_at_ack);
    check("status_busy_ovr", {24'd0, rdat}, 32'h05);
    eng_busy = 1'b0;
    xfer(1'b1, 1'b0, 17'h10001, 8'h04, 1'b0, waits, rdat, eng_at_ack);
    xfer(1'b0, 1'b1, 17'h10001, 8'h00, 1'b0, waits, rdat, eng_at_ack);
    check("ovr_cleared", {24'd0, rdat}, 32'h00);

    // DONE sticky flag
    @(posedge clk_clk); #1;
    eng_done = 1'b1;
    @(posedge clk_clk); #1;
    eng_done = 1'b0;
    xfer(1'b0, 1'b1, 17'h10001, 8'h00, 1'b0, waits, rdat, eng_at_ack);
    check("done_set", {24'd0, rdat}, 32'h02);
    xfer(1'b1, 1'b0, 17'h10001, 8'h02, 1'b1, waits, rdat, eng_at_ack);
    xfer(1'b0, 1'b1, 17'h10001, 8'h00, 1'b0, waits, rdat, eng_at_ack);
    check("done_set_beats_clear", {24'd0, rdat}, 32'h02);
    xfer(1'b1, 1'b0, 17'h10001, 8'h02, 1'b0, waits, rdat, eng_at_ack);
    xfer(1'b0, 1'b1, 17'h10001, 8'h00, 1'b0, waits, rdat, eng_at_ack);
    check("done_cleared", {24'd0, rdat}, 32'h00);

    // Same-address collision between Avalon write and engine read
    xfer(1'b1, 1'b0, 17'h00123, 8'h11, 1'b0, waits, rdat, eng_at_ack);
    eng_rd_addr = 16'h0123;
    xfer(1'b1, 1'b0, 17'h00123, 8'hA7, 1'b0, waits, rdat, eng_at_ack);
    check("collision_old_data", {24'd0, eng_at_ack}, 32'h11);
    check("collision_new_data", {24'd0, eng_rd_data}, 32'hA7);

    // Bit 16 set selects registers, not the buffer
    xfer(1'b1, 1'b0, 17'h10123, 8'h44, 1'b0, waits, rdat, eng_at_ack);
    check("reg_alias_img_h", {24'd0, eng_img_h}, 32'h44);
    @(posedge clk_clk); #1;
    check("reg_alias_buf_untouched", {24'd0, eng_rd_data}, 32'hA7);

`ifdef AVS_ACCESS_CNT_EN
    xfer(1'b1, 1'b0, 17'h10006, 8'h5C, 1'b0, waits, rdat, eng_at_ack);
    for (int k = 0; k < 4; k++) begin
      xfer(1'b0, 1'b1, 17'h10004, 8'h00, 1'b0, waits, rdat, eng_at_ack);
    end
    xfer(1'b0, 1'b1, 17'h10006, 8'h00, 1'b0, waits, rdat, eng_at_ack);
    check("acc_lo_five", {24'd0, rdat}, 32'h05);
    xfer(1'b0, 1'b1, 17'h10007, 8'h00, 1'b0, waits, rdat, eng_at_ack);
    check("acc_hi_zero", {24'd0, rdat}, 32'h00);
`else
    xfer(1'b1, 1'b0, 17'h10006, 8'hFF, 1'b0, waits, rdat, eng_at_ack);
    xfer(1'b0, 1'b1, 17'h10006, 8'h00, 1'b0, waits, rdat, eng_at_ack);
    check("acc_lo_absent", {24'd0, rdat}, 32'h00);
    xfer(1'b0, 1'b1, 17'h10007, 8'h00, 1'b0, waits, rdat, eng_at_ack);
    check("acc_hi_absent", {24'd0, rdat}, 32'h00);
`endif

    // Reset during the request cycle of a buffer write: no commit
    xfer(1'b1, 1'b0, 17'h00050, 8'h3C, 1'b0, waits, rdat, eng_at_ack);
    @(posedge clk_clk); #1;
    avs_s0_write     = 1'b1;
    avs_s0_address   = 17'h00050;
    avs_s0_writedata = 8'h77;
    #2;
    reset_reset = 1'b1;
    @(posedge clk_clk); #1;
    avs_s0_write = 1'b0;
    @(posedge clk_clk); #1;
    reset_reset = 1'b0;
    check("rst_clears_img_h", {24'd0, eng_img_h}, 32'h00);
    xfer(1'b0, 1'b1, 17'h00050, 8'h00, 1'b0, waits, rdat, eng_at_ack);
    check("rst_write_dropped", {24'd0, rdat}, 32'h3C);

    // Reset in RD_WAIT with the read held across it
    @(posedge clk_clk); #1;
    avs_s0_read    = 1'b1;
    avs_s0_address = 17'h00010;
    @(posedge clk_clk); #1;
    reset_reset = 1'b1;
    #1;
    check("rdwait_rst_readdata", {24'd0, avs_s0_readdata}, 32'h00);
    check("rdwait_rst_waitreq", {31'd0, avs_s0_waitrequest}, 32'd1);
    @(posedge clk_clk); #1;
    reset_reset = 1'b0;
    waits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_clk);
      if (avs_s0_waitrequest !== 1'b1) break;
      waits = waits + 1;
    end
    check("rdwait_restart_waits", waits, 32'd2);
    check("rdwait_restart_data", {24'd0, avs_s0_readdata}, 32'h5A);
    @(posedge clk_clk); #1;
    avs_s0_read = 1'b0;
    repeat (2) @(posedge clk_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
